// File: rtl/hdl_pkg.sv
// Shared constants and helpers for the datapath storage elements.
package hdl_pkg;

    // Per-bit reset value; replicated to the word width at each use site.
    localparam logic REG_RESET = 1'b0;

    // Address width for a given depth, never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/demux_n.sv
// N-way write-enable decoder: one-hot select, all zeros when disabled or out of range.
module demux_n #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          i_en,
    input  logic [AW-1:0] i_addr,
    output logic [N-1:0]  o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_en && (32'(i_addr) == i)) begin
                o_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Register bank: one write port, two combinational read ports, sync clear, optional bypass.
module reg_bank
    import hdl_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = addr_width(DEPTH),
    parameter int BYPASS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] w_we_onehot;
    logic [WIDTH-1:0] w_mem_a;
    logic [WIDTH-1:0] w_mem_b;
    logic             w_wr_live;
    logic             w_hit_a;
    logic             w_hit_b;

    demux_n #(
        .N  (DEPTH),
        .AW (AW)
    ) u_wr_demux (
        .i_en     (we),
        .i_addr   (waddr),
        .o_onehot (w_we_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{REG_RESET}};
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{REG_RESET}};
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_we_onehot[i]) begin
                    r_mem[i] <= wdata;
                end
            end
        end
    end

    // Read muxes compare against every in-range index, so out-of-range reads fall to zero.
    always_comb begin
        w_mem_a = '0;
        w_mem_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(raddr_a) == i) begin
                w_mem_a = r_mem[i];
            end
            if (32'(raddr_b) == i) begin
                w_mem_b = r_mem[i];
            end
        end
    end

    assign w_wr_live = (|w_we_onehot) && !clr;
    assign w_hit_a   = (BYPASS != 0) && w_wr_live && (raddr_a == waddr);
    assign w_hit_b   = (BYPASS != 0) && w_wr_live && (raddr_b == waddr);

    assign rdata_a = w_hit_a ? wdata : w_mem_a;
    assign rdata_b = w_hit_b ? wdata : w_mem_b;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: three instances (no bypass, bypass, depth 6 with bypass) share stimulus.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] d0_a, d0_b, d1_a, d1_b, d2_a, d2_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(d0_a), .raddr_b(raddr_b), .rdata_b(d0_b)
    );

    reg_bank #(.WIDTH(16), .DEPTH(8), .BYPASS(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(d1_a), .raddr_b(raddr_b), .rdata_b(d1_b)
    );

    reg_bank #(.WIDTH(16), .DEPTH(6), .BYPASS(1)) u_d2 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .rdata_a(d2_a), .raddr_b(raddr_b), .rdata_b(d2_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr_a = 3'd3;
        raddr_b = 3'd0;
        #2;
        chk("reset_d0_a", d0_a, 16'h0000);
        chk("reset_d1_b", d1_b, 16'h0000);
        #1 rst_n = 1'b1;

        // Asynchronous reset between edges
        wr(3'd3, 16'hBEEF);
        chk("wr_beef", d0_a, 16'hBEEF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_d0", d0_a, 16'h0000);
        chk("async_rst_d1", d1_a, 16'h0000);
        chk("async_rst_d2", d2_a, 16'h0000);
        rst_n = 1'b1;
        tick();

        // Basic write / dual read
        wr(3'd5, 16'h1234);
        wr(3'd0, 16'hABCD);
        raddr_a = 3'd5;
        raddr_b = 3'd0;
        #1;
        chk("rd_a5_d0", d0_a, 16'h1234);
        chk("rd_b0_d0", d0_b, 16'hABCD);
        chk("rd_a5_d2", d2_a, 16'h1234);
        chk("rd_b0_d1", d1_b, 16'hABCD);
        for (int i = 1; i < 8; i++) begin
            if (i != 5) begin
                raddr_a = 3'(i);
                #1;
                chk("rd_other_d0", d0_a, 16'h0000);
                chk("rd_other_d2", d2_a, 16'h0000);
            end
        end

        // Same-cycle bypass behaviour
        wr(3'd2, 16'h0001);
        we      = 1'b1;
        waddr   = 3'd2;
        wdata   = 16'h00FF;
        raddr_a = 3'd2;
        raddr_b = 3'd0;
        #1;
        chk("nobyp_same", d0_a, 16'h0001);
        chk("byp_same", d1_a, 16'h00FF);
        chk("byp_same_d2", d2_a, 16'h00FF);
        chk("byp_other_port", d1_b, 16'hABCD);
        tick();
        we = 1'b0;
        #1;
        chk("nobyp_next", d0_a, 16'h00FF);

        // Back-to-back writes to one address
        raddr_a = 3'd1;
        raddr_b = 3'd1;
        wr(3'd1, 16'h1111);
        wr(3'd1, 16'h2222);
        chk("b2b_last_wins", d0_a, 16'h2222);

        // Dual-port same address
        wr(3'd1, 16'h0A0A);
        chk("dual_a", d0_a, 16'h0A0A);
        chk("dual_b", d0_b, 16'h0A0A);

        // Clear has priority over write and suppresses bypass
        for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF);
        clr     = 1'b1;
        we      = 1'b1;
        waddr   = 3'd4;
        wdata   = 16'h5555;
        raddr_a = 3'd4;
        #1;
        chk("clr_pre_d0", d0_a, 16'hFFFF);
        chk("clr_nobyp_d1", d1_a, 16'hFFFF);
        chk("clr_nobyp_d2", d2_a, 16'hFFFF);
        tick();
        clr = 1'b0;
        we  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i);
            #1;
            chk("clr_post_d0", d0_a, 16'h0000);
            chk("clr_post_d1", d1_a, 16'h0000);
            chk("clr_post_d2", d2_a, 16'h0000);
        end

        // Non-power-of-two depth: writes beyond DEPTH are dropped
        for (int i = 0; i < 6; i++) wr(3'(i), 16'h1000 + 16'(i));
        we      = 1'b1;
        waddr   = 3'd6;
        wdata   = 16'h7777;
        raddr_a = 3'd6;
        #1;
        chk("oor_nobyp_d2", d2_a, 16'h0000);
        chk("inrange_byp_d1", d1_a, 16'h7777);
        chk("inrange_nobyp_d0", d0_a, 16'h0000);
        tick();
        wr(3'd7, 16'h7777);
        for (int i = 0; i < 8; i++) begin
            raddr_b = 3'(i);
            #1;
            chk("depth6_d2", d2_b, (i < 6) ? 16'h1000 + 16'(i) : 16'h0000);
        end
        raddr_a = 3'd6;
        raddr_b = 3'd7;
        #1;
        chk("depth8_addr6", d0_a, 16'h7777);
        chk("depth8_addr7", d0_b, 16'h7777);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised multi-port register bank, the next step after the two-way mux/demux primitives: an N-way demultiplexed write path and N-way multiplexed read paths around clocked storage words. It provides the team's first stateful storage element for the datapath, such as the CPU register file or a small scratch RAM. It supports one write port and two independent read ports, a synchronous bulk clear, and optional write-to-read bypass.

## Interface
- `WIDTH`, 16, bits per word (≥1)
- `DEPTH`, 8, number of words (≥2; need not be a power of two)
- `AW`, `$clog2(DEPTH)`, address width (derived; not overridden)
- `BYPASS`, 0, 1 = a read of the address being written returns `wdata` in the same cycle
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `clr`  in  1  synchronous clear of all words
- `we`  in  1  write enable
- `waddr`  in  AW  write address
- `wdata`  in  WIDTH  write data
- `raddr_a`  in  AW  read address, port A
- `rdata_a`  out  WIDTH  read data, port A
- `raddr_b`  in  AW  read address, port B
- `rdata_b`  out  WIDTH  read data, port B

## Operation
- Storage: DEPTH words × WIDTH bits. Nothing else holds state.
- Reset: `rst_n`=0 forces every word to 0 immediately, without waiting for a clock edge. While reset is asserted, `rdata_a` and `rdata_b` read 0, except that a `BYPASS`=1 hit may still forward `wdata` (see below). Deasserting reset mid-write has no side effect; the first write takes effect on the first rising edge with `rst_n`=1.
- Write: on the rising edge with `we`=1 and `waddr` < DEPTH, `mem[waddr]` ← `wdata`. All other words hold their value.
- Out-of-range write (`waddr` ≥ DEPTH): ignored, and no word changes.
- Clear: on the rising edge with `clr`=1, all words ← 0. `clr` has priority over `we` in the same cycle, so the write is dropped.
- Read: combinational. `rdata_x` = `mem[raddr_x]`. If `raddr_x` ≥ DEPTH, `rdata_x` = 0.
- Both ports may address the same word and both return it.
- Bypass with `BYPASS`=0: a same-cycle read of the word being written returns the old contents. The new value is visible after the edge.
- Bypass with `BYPASS`=1: if `we`=1, `clr`=0, `waddr` < DEPTH and `raddr_x`==`waddr`, then `rdata_x` = `wdata` combinationally. This applies to each port independently. No bypass occurs when `clr`=1.
- No arithmetic on data. Widths are exact, with no truncation or extension.

## Timing
- Write-to-read latency: 1 cycle with `BYPASS`=0, 0 cycles with `BYPASS`=1.
- Read path: purely combinational, address to data. No registered outputs.
- Clear-to-read latency: 1 cycle. Reads on the cycle after `clr` return 0.
- Reset-to-read: 0 regardless of clock, because reset is asynchronous.
- Back-to-back writes to the same address: the last write wins each cycle.
- Simultaneous `clr`, `we` and reads in one cycle: reads show the pre-edge contents (or `wdata` per bypass rules, suppressed by `clr`). After the edge, all words are 0.

## Structure
- Shared package `hdl_pkg` holds the reset-value constant `REG_RESET` (all zeros) and a helper for the derived `AW`.
- Sub-module `demux_n` (parameter `N`) converts `we`/`waddr` into an N-bit one-hot write-enable vector. An out-of-range address produces all zeros. This generalises the two-way demux.
- Read selection is an N-way mux generalising `mux`. It is instantiated twice inline or as `mux_n`; a separate file is optional.

## Test plan
- Reset: `WIDTH`=16, `DEPTH`=8. Write 0xBEEF to address 3, then pulse `rst_n`=0 between clock edges. `rdata_a` (`raddr_a`=3) must read 0x0000 before the next edge.
- Write/read: write 0x1234 to address 5 and 0xABCD to address 0. With `raddr_a`=5 and `raddr_b`=0, the bench must see `rdata_a`=0x1234 and `rdata_b`=0xABCD the cycle after. Other addresses read 0.
- Bypass: with `BYPASS`=0, address 2 holds 0x0001 and the bench writes 0x00FF to it with `raddr_a`=2. The same cycle must read 0x0001 and the next cycle 0x00FF. Repeat with `BYPASS`=1: the same cycle must read 0x00FF.
- Clear priority: fill all words with 0xFFFF, then assert `clr`=1, `we`=1, `waddr`=4, `wdata`=0x5555 together. Next cycle, every address reads 0x0000, including 4.
- Non-power-of-two depth: `DEPTH`=6, `AW`=3. Write 0x7777 to address 6 and 7. Every address 0–5 is unchanged, and reads of 6/7 return 0x0000.
- Dual-port same address: both ports read address 1 after writing 0x0A0A. Both return 0x0A0A in the same cycle.
